// File: rtl/capture_pkg.sv
// Shared types and constants for the logic-analyzer capture path.
// Pure declarations; no timing or flow control of its own.
`timescale 1ns/1ps
package capture_pkg;

    localparam int PROBE_CHANNELS = 8;
    localparam int FIFO_DEPTH     = 32768;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ARMED,
        ST_CAPTURE,
        ST_DONE
    } capture_state_t;

    // A channel outside the mask never blocks a match, so mask = 0 always matches.
    function automatic logic probe_match(input logic [PROBE_CHANNELS-1:0] sample,
                                         input logic [PROBE_CHANNELS-1:0] value,
                                         input logic [PROBE_CHANNELS-1:0] mask);
        return ((sample ^ value) & mask) == '0;
    endfunction

endpackage

// File: rtl/sample_prescaler.sv
// Sample-rate divider: tick once every div+1 clocks, combinationally from the count.
// Zero latency on tick; load restarts the count at 0 on the next edge. No backpressure.
`timescale 1ns/1ps
module sample_prescaler #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] cnt_d;

    assign tick = (cnt_q == div);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (load || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sample_capture.sv
// Capture controller: sync probes, wait for trigger, stream post-trigger samples to sample_fifo.
// Sample path is 2 flops; write strobe is combinational and never issued while fifo_full.
`timescale 1ns/1ps
module sample_capture import capture_pkg::*; #(
    parameter int DIV_WIDTH   = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [PROBE_CHANNELS-1:0] probe_in,
    input  logic                      arm,
    input  logic                      abort,
    input  logic [DIV_WIDTH-1:0]      divider,
    input  logic [PROBE_CHANNELS-1:0] trig_mask,
    input  logic [PROBE_CHANNELS-1:0] trig_value,
    input  logic                      trig_edge,
    input  logic [COUNT_WIDTH-1:0]    post_count,
    output logic                      fifo_wr_en,
    output logic                      fifo_clear,
    output logic [PROBE_CHANNELS-1:0] fifo_data,
    input  logic                      fifo_full,
    output logic                      busy,
    output logic                      triggered,
    output logic                      done,
    output logic                      overflow,
    output logic [COUNT_WIDTH-1:0]    stored_count
);

    capture_state_t            state_q, state_d;
    logic [PROBE_CHANNELS-1:0] sync1_q, data_q;
    logic [DIV_WIDTH-1:0]      div_l_q;
    logic [PROBE_CHANNELS-1:0] mask_l_q, value_l_q;
    logic                      edge_l_q;
    logic [COUNT_WIDTH-1:0]    post_l_q;
    logic                      prev_match_q, triggered_q, done_q, overflow_q, clear_q;
    logic [COUNT_WIDTH-1:0]    count_q, count_inc;
    logic                      tick, match, trig_hit, arm_ok;

    sample_prescaler #(.DIV_WIDTH(DIV_WIDTH)) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (state_q == ST_CLEAR),
        .div     (div_l_q),
        .tick    (tick)
    );

    assign match     = probe_match(data_q, value_l_q, mask_l_q);
    assign trig_hit  = edge_l_q ? (match && !prev_match_q) : match;
    assign count_inc = count_q + 1'b1;
    assign arm_ok    = arm && !abort && (state_q == ST_IDLE || state_q == ST_DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: if (arm) state_d = ST_CLEAR;
                ST_CLEAR:         state_d = ST_ARMED;
                ST_ARMED: begin
                    if (tick && trig_hit) begin
                        if (fifo_full || post_l_q == COUNT_WIDTH'(1)) state_d = ST_DONE;
                        else                                          state_d = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (tick) begin
                        if (fifo_full) state_d = ST_DONE;
                        else if (post_l_q != '0 && count_inc == post_l_q) state_d = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // fifo_full already accounts for the previous edge's write, so this can fire every clock.
    always_comb begin
        fifo_wr_en = 1'b0;
        busy       = 1'b0;
        case (state_q)
            ST_CLEAR: busy = 1'b1;
            ST_ARMED: begin
                busy       = 1'b1;
                fifo_wr_en = tick && trig_hit && !fifo_full && !abort;
            end
            ST_CAPTURE: begin
                busy       = 1'b1;
                fifo_wr_en = tick && !fifo_full && !abort;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            data_q  <= '0;
        end else begin
            sync1_q <= probe_in;
            data_q  <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_l_q   <= '0;
            mask_l_q  <= '0;
            value_l_q <= '0;
            edge_l_q  <= 1'b0;
            post_l_q  <= '0;
        end else if (arm_ok) begin
            div_l_q   <= divider;
            mask_l_q  <= trig_mask;
            value_l_q <= trig_value;
            edge_l_q  <= trig_edge;
            post_l_q  <= post_count;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clear_q      <= 1'b0;
            prev_match_q <= 1'b1;
            triggered_q  <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            count_q      <= '0;
        end else begin
            clear_q <= (state_d == ST_CLEAR);
            if (arm_ok) begin
                triggered_q <= 1'b0;
                done_q      <= 1'b0;
                overflow_q  <= 1'b0;
                count_q     <= '0;
            end else if (!abort) begin
                if (state_q == ST_CLEAR) prev_match_q <= 1'b1;
                if (state_q == ST_ARMED && tick) begin
                    prev_match_q <= match;
                    if (trig_hit) begin
                        triggered_q <= 1'b1;
                        if (fifo_full) overflow_q <= 1'b1;
                    end
                end
                if (state_q == ST_CAPTURE && tick && fifo_full) overflow_q <= 1'b1;
                if (fifo_wr_en) count_q <= count_inc;
                if (state_d == ST_DONE && state_q != ST_DONE) done_q <= 1'b1;
            end
        end
    end

    assign fifo_clear   = clear_q;
    assign fifo_data    = data_q;
    assign triggered    = triggered_q;
    assign done         = done_q;
    assign overflow     = overflow_q;
    assign stored_count = count_q;

endmodule

// File: tb/tb_sample_capture.sv
// Scoreboard bench for sample_capture: a tick-level reference model predicts every FIFO write.
`timescale 1ns/1ps
module tb_sample_capture;
    import capture_pkg::*;

    localparam int DW = 16;
    localparam int CW = 16;
    localparam int SEQ_LEN = 34000;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    probe_in = '0;
    logic          arm = 1'b0, abort = 1'b0;
    logic [DW-1:0] divider = '0;
    logic [7:0]    trig_mask = '0, trig_value = '0;
    logic          trig_edge = 1'b0;
    logic [CW-1:0] post_count = '0;
    logic          fifo_wr_en, fifo_clear, fifo_full, busy, triggered, done, overflow;
    logic [7:0]    fifo_data;
    logic [CW-1:0] stored_count;

    sample_capture #(.DIV_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n), .probe_in(probe_in), .arm(arm), .abort(abort),
        .divider(divider), .trig_mask(trig_mask), .trig_value(trig_value),
        .trig_edge(trig_edge), .post_count(post_count), .fifo_wr_en(fifo_wr_en),
        .fifo_clear(fifo_clear), .fifo_data(fifo_data), .fifo_full(fifo_full),
        .busy(busy), .triggered(triggered), .done(done), .overflow(overflow),
        .stored_count(stored_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural sample_fifo occupancy; full reflects writes up to the last edge.
    int fifo_occ = 0;
    always @(posedge clk) begin
        if (fifo_clear)      fifo_occ <= 0;
        else if (fifo_wr_en) fifo_occ <= fifo_occ + 1;
    end
    assign fifo_full = (fifo_occ >= FIFO_DEPTH);

    typedef struct {
        int         cyc;
        logic [7:0] dat;
    } wr_t;
    wr_t exp_q[$];

    logic [7:0] seq [0:SEQ_LEN-1];
    int checks = 0, errors = 0, clear_cnt = 0, last_clear = -1;
    int m_cnt, m_end_rel;
    bit m_trig, m_ovf, m_done;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic monitor();
        wr_t e;
        forever begin
            @(negedge clk);
            if (fifo_clear) begin
                clear_cnt++;
                last_clear = cyc;
            end
            if (fifo_wr_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected cyc=%0d data=%h expected no write", cyc, fifo_data);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.dat !== fifo_data) begin
                        errors++;
                        $display("FAIL write cyc=%0d data=%h expected cyc=%0d data=%h",
                                 cyc, fifo_data, e.cyc, e.dat);
                    end
                end
            end
        end
    endtask

    // Ticks fall on sample indices d, 2d+1, 3d+2, ...; sample index i is seq[i] seen at arm+2+i.
    // Only ticks strictly before the stop cycle (abort/reset) can write.
    task automatic build_expected(input int arm_c, input int d, input logic [7:0] mask,
                                  input logic [7:0] val, input logic edg, input int post,
                                  input int stop);
        int   idx, occ;
        logic mt, hit, prev, trg;
        prev = 1'b1; trg = 1'b0; occ = 0;
        m_trig = 0; m_ovf = 0; m_done = 0; m_end_rel = 1 << 30;
        for (int k = 0; ; k++) begin
            idx = d + k * (d + 1);
            if (2 + idx >= stop) break;
            mt = (((seq[idx] ^ val) & mask) == 8'h00);
            if (!trg) begin
                hit  = edg ? (mt && !prev) : mt;
                prev = mt;
                if (!hit) continue;
                trg = 1'b1;
                m_trig = 1;
            end
            if (occ == FIFO_DEPTH) begin
                m_ovf = 1; m_done = 1; m_end_rel = 3 + idx;
                break;
            end
            exp_q.push_back('{cyc: arm_c + 2 + idx, dat: seq[idx]});
            occ++;
            if (post != 0 && occ == post) begin
                m_done = 1; m_end_rel = 3 + idx;
                break;
            end
        end
        m_cnt = occ;
    endtask

    // kind 0: run to completion (abort at stop if still busy); 1: abort at stop; 2: async reset at stop.
    task automatic run_scn(input string name, input int d, input logic [7:0] mask,
                           input logic [7:0] val, input logic edg, input int post,
                           input int stop, input int kind);
        int arm_c, clr0;
        @(posedge clk); #1;
        arm_c      = cyc;
        clr0       = clear_cnt;
        divider    = DW'(d);
        trig_mask  = mask;
        trig_value = val;
        trig_edge  = edg;
        post_count = CW'(post);
        probe_in   = seq[0];
        arm        = 1'b1;
        build_expected(arm_c, d, mask, val, edg, post, stop);
        for (int i = 1; i <= stop; i++) begin
            @(posedge clk); #1;
            arm        = 1'b0;
            abort      = 1'b0;
            divider    = DW'($urandom);
            trig_mask  = 8'($urandom);
            trig_value = 8'($urandom);
            trig_edge  = 1'($urandom);
            post_count = CW'($urandom);
            probe_in   = seq[i];
            if (i == 3 && !(m_done && m_end_rel <= 3)) arm = 1'b1;
            if (i == stop) begin
                if (kind == 2) begin
                    #2 reset_n = 1'b0;
                    #1;
                    chk({name, "_rst_wr_en"}, fifo_wr_en, 0);
                    chk({name, "_rst_clear"}, fifo_clear, 0);
                    chk({name, "_rst_busy"}, busy, 0);
                    chk({name, "_rst_triggered"}, triggered, 0);
                    chk({name, "_rst_overflow"}, overflow, 0);
                    chk({name, "_rst_data"}, fifo_data, 0);
                    chk({name, "_rst_stored"}, stored_count, 0);
                end else if (!m_done) begin
                    abort = 1'b1;
                    arm   = 1'b1;
                end
            end
        end
        @(posedge clk); #1;
        arm = 1'b0; abort = 1'b0;
        if (kind == 2) begin
            repeat (2) @(posedge clk);
            #3 reset_n = 1'b1;
        end
        repeat (3) @(posedge clk);
        #2;
        chk({name, "_busy"}, busy, 0);
        if (kind == 2) begin
            chk({name, "_done"}, done, 0);
            chk({name, "_triggered"}, triggered, 0);
            chk({name, "_overflow"}, overflow, 0);
            chk({name, "_stored"}, stored_count, 0);
        end else begin
            chk({name, "_done"}, done, longint'(m_done));
            chk({name, "_triggered"}, triggered, longint'(m_trig));
            chk({name, "_overflow"}, overflow, longint'(m_ovf));
            chk({name, "_stored"}, stored_count, m_cnt);
        end
        chk({name, "_clear_pulses"}, clear_cnt - clr0, 1);
        chk({name, "_clear_cycle"}, last_clear, arm_c + 1);
        chk({name, "_writes_missing"}, exp_q.size(), 0);
        chk({name, "_fifo_level"}, fifo_occ, m_cnt);
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] v;
        fork
            monitor();
        join_none

        #2;
        chk("reset_wr_en", fifo_wr_en, 0);
        chk("reset_clear", fifo_clear, 0);
        chk("reset_busy", busy, 0);
        chk("reset_triggered", triggered, 0);
        chk("reset_done", done, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_data", fifo_data, 0);
        chk("reset_stored", stored_count, 0);
        #15 reset_n = 1'b1;
        repeat (3) @(posedge clk);

        for (int i = 0; i < SEQ_LEN; i++) seq[i] = 8'(i);
        run_scn("ramp", 0, 8'h00, 8'h00, 1'b0, 5, 20, 0);

        for (int i = 0; i < 80; i++) seq[i] = (i < 20) ? 8'h00 : 8'hA5;
        run_scn("level_div3", 3, 8'hFF, 8'hA5, 1'b0, 4, 60, 0);

        for (int i = 0; i < 60; i++) begin
            v = 8'($urandom) & 8'hFE;
            seq[i] = (i >= 10 && i < 15) ? v : (v | 8'h01);
        end
        run_scn("edge_bit0", 0, 8'h01, 8'h01, 1'b1, 3, 40, 0);

        for (int i = 0; i < 60; i++) seq[i] = 8'($urandom);
        run_scn("abort10", 0, 8'h00, 8'h00, 1'b0, 0, 12, 1);

        for (int i = 0; i < 60; i++) seq[i] = 8'($urandom);
        run_scn("reset_mid", 1, 8'h00, 8'h00, 1'b0, 0, 15, 2);

        for (int r = 0; r < 6; r++) begin
            int         d, post;
            logic [7:0] mask, val;
            logic       edg;
            d    = $urandom_range(0, 3);
            post = $urandom_range(1, 6);
            mask = 8'($urandom);
            val  = 8'($urandom);
            edg  = 1'($urandom);
            for (int i = 0; i < 80; i++)
                seq[i] = ($urandom_range(0, 2) == 0) ? val : 8'($urandom);
            run_scn($sformatf("rand%0d", r), d, mask, val, edg, post, 70, 0);
        end

        for (int i = 0; i < SEQ_LEN; i++) seq[i] = 8'($urandom);
        run_scn("fill_full", 0, 8'h00, 8'h00, 1'b0, 0, FIFO_DEPTH + 10, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sample_capture.md
# sample_capture

Capture controller that sits directly upstream of `sample_fifo` in the logic-analyzer datapath. It synchronises the 8 probe inputs, divides the sample rate, and waits for a masked pattern or edge trigger. It then streams post-trigger samples into the FIFO until a programmed count is reached or the FIFO fills. The FIFO readout path may drain the FIFO only while this block reports `busy = 0`.

## Interface
- `DIV_WIDTH`, 16: width of the sample-rate divider.
- `COUNT_WIDTH`, 16: width of the post-trigger count and the stored-sample counter.
- `clk`  in  1  system clock. One clock domain; all logic on its rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `probe_in`  in  8  raw probe channels, asynchronous to `clk`.
- `arm`  in  1  single-cycle pulse; starts a capture. Ignored while `busy`.
- `abort`  in  1  single-cycle pulse; stops any capture. Has priority over everything except reset.
- `divider`  in  DIV_WIDTH  one sample tick every `divider+1` clocks. Latched on `arm`.
- `trig_mask`  in  8  channels that take part in the trigger. Latched on `arm`.
- `trig_value`  in  8  required level on each masked channel. Latched on `arm`.
- `trig_edge`  in  1  trigger mode. 0 = level match; 1 = transition from no-match to match. Latched on `arm`.
- `post_count`  in  COUNT_WIDTH  samples to store, trigger sample included. 0 = store until the FIFO is full. Latched on `arm`.
- `fifo_wr_en`  out  1  write strobe to the FIFO `en` (`rnw` = 0). Combinational.
- `fifo_clear`  out  1  one-cycle clear pulse to the FIFO. Registered.
- `fifo_data`  out  8  synchronised sample. Registered.
- `fifo_full`  in  1  FIFO full flag. Reflects all writes up to the last clock edge.
- `busy`  out  1  high in CLEAR, ARMED and CAPTURE.
- `triggered`  out  1  sticky; set on the trigger, cleared on `arm`.
- `done`  out  1  sticky; set on entry to DONE, cleared on `arm`.
- `overflow`  out  1  sticky; set when the capture was ended by `fifo_full`.
- `stored_count`  out  COUNT_WIDTH  number of samples written in the current capture.

## Operation
- States: IDLE, CLEAR, ARMED, CAPTURE, DONE.
- **IDLE, DONE + `arm`:**
  - Latch all configuration inputs.
  - Clear `triggered`, `done`, `overflow` and `stored_count`.
  - Go to CLEAR.
- **CLEAR:**
  - `fifo_clear` = 1 for exactly this cycle.
  - Reset the prescaler to 0 and set `prev_match` = 1.
  - Go to ARMED next cycle.
- **Prescaler:** counts 0..`div_l`. `tick` = 1 when the count equals `div_l`, then the count wraps to 0. With `div_l` = 0, `tick` is high every cycle.
- **Match:** `match = ((sample ^ value_l) & mask_l) == 0`. `mask_l` = 0 always matches.
- **ARMED, on `tick`:**
  - Trigger condition: `match` when `edge_l` = 0; `match && !prev_match` when `edge_l` = 1.
  - `prev_match` is updated with `match` on every tick.
  - `prev_match` starts at 1, so in edge mode a bus that already matches does not trigger.
- **On trigger:**
  - The same cycle asserts `fifo_wr_en` with the trigger sample on `fifo_data`.
  - `stored_count` becomes 1 and `triggered` is set.
  - Go to CAPTURE, or to DONE if `post_count_l` = 1.
- **CAPTURE, on `tick`:**
  - If `fifo_full` = 1: no write, set `overflow`, go to DONE.
  - Otherwise write and increment `stored_count`.
  - If the new count equals `post_count_l` (and `post_count_l` ≠ 0), go to DONE.
- **Trigger tick with `fifo_full` = 1:** not written. Set `triggered` and `overflow`, go to DONE. This cannot occur after a normal CLEAR.
- **DONE:** `done` = 1 and outputs hold until `arm`.
- **`abort` in any state:**
  - `fifo_wr_en` is forced to 0 in that cycle.
  - Next state is IDLE. `done` stays 0.
  - `triggered`, `overflow` and `stored_count` keep their values.
- **`arm` and `abort` in the same cycle:** `abort` wins; the block goes to IDLE and the configuration is not latched.
- **Reset:** all state is discarded. `fifo_data` keeps no history.

## Timing
- **Reset values:**
  - `fifo_wr_en`, `fifo_clear`, `busy`, `triggered`, `done`, `overflow` = 0.
  - `fifo_data` = 0, `stored_count` = 0.
  - State = IDLE, prescaler = 0, synchroniser flops = 0.
- **Probe path:** `probe_in` passes through a 2-flop synchroniser. `fifo_data` is the second flop, so a change seen at edge k appears on `fifo_data` after edge k+1.
- **Arm timing:** `arm` at edge a gives CLEAR during cycle a+1 and ARMED from a+2. The first possible trigger tick is at cycle a+2+`div_l`.
- **Write strobe:**
  - `fifo_wr_en` = f(state, `tick`, match, `fifo_full`, `abort`); no register in the path.
  - Because `fifo_full` already reflects the previous edge's write, back-to-back writes at `div_l` = 0 never overfill the FIFO.
- **Throughput:** one write per tick, at most one per clock. Counters wrap only at 2^COUNT_WIDTH, which is never reached because the FIFO depth is 32768.

## Structure
- Package `capture_pkg` holds:
  - `capture_state_t`, the enum of the five states.
  - `PROBE_CHANNELS` = 8.
  - `FIFO_DEPTH` = 32768.
- Sub-module `sample_prescaler` holds the divider counter. Inputs: `clk`, `reset_n`, `load`, `div`. Output: `tick`.
- The top level maps `en = fifo_wr_en | rd_en` and `rnw = rd_en`. The reader is gated by `!busy`.

## Test plan
- `divider`=0, `mask`=0, `post_count`=5, ramp 0,1,2,… on probes → `fifo_clear` one cycle, then 5 consecutive writes, FIFO holds 5 consecutive values, `done`=1, `stored_count`=5, `overflow`=0.
- `divider`=3, `mask`=0xFF, `value`=0xA5, level mode, probes 0x00 for 20 clocks then 0xA5 → first write is 0xA5, writes exactly every 4 clocks, no write before the match.
- Edge mode, `mask`=0x01, `value`=0x01, probe bit0 held 1 at arm → no trigger. Drop to 0, rise to 1 → trigger on the rising sample only.
- `post_count`=0, `divider`=0 → exactly 32768 writes, `fifo_full`=1, `overflow`=1, `done`=1, `stored_count`=32768. No write is attempted after full.
- `abort` mid-CAPTURE after 10 writes → `fifo_wr_en` low the same cycle, IDLE next, `done`=0, `stored_count`=10. A new `arm` then clears the FIFO and restarts.
- `reset_n` pulled low asynchronously mid-CAPTURE → all outputs 0 immediately, no further writes. `arm` while `busy` is ignored.
